// File: rtl/reg_file_sb.sv
// Two-write-port register file with pending-load scoreboard, optional bypass and optional zero register.
// Writes, locks and clears commit at the rising edge; reads are combinational; never stalls.
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] busA,
  output logic [DATA_W-1:0] busB,
  output logic              busyA,
  output logic              busyB,
  input  logic              regWr,
  input  logic [ADDR_W-1:0] rw,
  input  logic [DATA_W-1:0] busW,
  input  logic              regWr2,
  input  logic [ADDR_W-1:0] rw2,
  input  logic [DATA_W-1:0] busW2,
  input  logic              lock,
  input  logic [ADDR_W-1:0] lock_addr,
  output logic              collide
);
  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic              collide_q, collide_d;

  logic we0, we1, lk;

  // With the zero register enabled, any access targeting register 0 is squashed here.
  always_comb begin
    we0 = regWr  && !((ZERO_REG != 0) && (rw == '0));
    we1 = regWr2 && !((ZERO_REG != 0) && (rw2 == '0));
    lk  = lock   && !((ZERO_REG != 0) && (lock_addr == '0));
  end

  always_comb begin
    regs_d    = regs_q;
    busy_d    = busy_q;
    collide_d = we0 && we1 && (rw == rw2);
    if (we1) regs_d[rw2] = busW2;
    if (we0) regs_d[rw]  = busW;
    if (we1) busy_d[rw2] = 1'b0;
    // A new lock issued alongside the returning load keeps the register pending.
    if (lk)  busy_d[lock_addr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q    <= '{default: '0};
      busy_q    <= '0;
      collide_q <= 1'b0;
    end else begin
      regs_q    <= regs_d;
      busy_q    <= busy_d;
      collide_q <= collide_d;
    end
  end

  always_comb begin
    busA  = regs_q[rs];
    busB  = regs_q[rt];
    busyA = busy_q[rs];
    busyB = busy_q[rt];
    if (BYPASS != 0) begin
      if (we1 && (rw2 == rs)) begin
        busA = busW2;
        if (!(lk && (lock_addr == rs))) busyA = 1'b0;
      end
      if (we0 && (rw == rs)) busA = busW;
      if (we1 && (rw2 == rt)) begin
        busB = busW2;
        if (!(lk && (lock_addr == rt))) busyB = 1'b0;
      end
      if (we0 && (rw == rt)) busB = busW;
    end
    if ((ZERO_REG != 0) && (rs == '0)) begin
      busA  = '0;
      busyA = 1'b0;
    end
    if ((ZERO_REG != 0) && (rt == '0)) begin
      busB  = '0;
      busyB = 1'b0;
    end
  end

  assign collide = collide_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: dut uses BYPASS=1/ZERO_REG=0, dut_z uses BYPASS=0/ZERO_REG=1, both on shared inputs.
module tb_reg_file_sb;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rs, rt, rw, rw2, lock_addr;
  logic [15:0] busW, busW2;
  logic        regWr, regWr2, lock;
  logic [15:0] busA, busB, z_busA, z_busB;
  logic        busyA, busyB, collide, z_busyA, z_busyB, z_collide;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(1), .ZERO_REG(0)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .busA(busA), .busB(busB),
    .busyA(busyA), .busyB(busyB), .regWr(regWr), .rw(rw), .busW(busW),
    .regWr2(regWr2), .rw2(rw2), .busW2(busW2), .lock(lock), .lock_addr(lock_addr),
    .collide(collide)
  );

  reg_file_sb #(.DATA_W(16), .ADDR_W(4), .BYPASS(0), .ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt), .busA(z_busA), .busB(z_busB),
    .busyA(z_busyA), .busyB(z_busyB), .regWr(regWr), .rw(rw), .busW(busW),
    .regWr2(regWr2), .rw2(rw2), .busW2(busW2), .lock(lock), .lock_addr(lock_addr),
    .collide(z_collide)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    regWr = 1'b0; regWr2 = 1'b0; lock = 1'b0; reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle(); reset = 1'b1;
    rs = 4'd0; rt = 4'd15; rw = '0; rw2 = '0; lock_addr = '0; busW = '0; busW2 = '0;
    tick(); tick();
    reset = 1'b0;
    #1;
    checks++; if (busA !== 16'h0000) begin errors++; $display("FAIL reset_busA: got %h want 0000", busA); end
    checks++; if (busB !== 16'h0000) begin errors++; $display("FAIL reset_busB: got %h want 0000", busB); end
    checks++; if ({busyA, busyB, collide} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {busyA, busyB, collide}); end
    checks++; if ({z_busA, z_busB} !== 32'h0) begin errors++; $display("FAIL reset_z_bus: got %h want 0", {z_busA, z_busB}); end
    checks++; if ({z_busyA, z_busyB, z_collide} !== 3'b000) begin errors++; $display("FAIL reset_z_flags: got %b want 000", {z_busyA, z_busyB, z_collide}); end
  endtask

  task automatic test_write_bypass();
    regWr = 1'b1; rw = 4'd1; busW = 16'hFFFF; rs = 4'd1;
    regWr2 = 1'b1; rw2 = 4'd2; busW2 = 16'h0F0F; rt = 4'd2;
    #1;
    checks++; if (busA !== 16'hFFFF) begin errors++; $display("FAIL bypass_p0: got %h want ffff", busA); end
    checks++; if (z_busA !== 16'h0000) begin errors++; $display("FAIL nobypass_p0: got %h want 0000", z_busA); end
    checks++; if (busB !== 16'h0F0F) begin errors++; $display("FAIL bypass_p1: got %h want 0f0f", busB); end
    checks++; if (z_busB !== 16'h0000) begin errors++; $display("FAIL nobypass_p1: got %h want 0000", z_busB); end
    tick(); idle(); #1;
    checks++; if (busA !== 16'hFFFF || z_busA !== 16'hFFFF) begin errors++; $display("FAIL write_p0: got %h/%h want ffff", busA, z_busA); end
    checks++; if (busB !== 16'h0F0F || z_busB !== 16'h0F0F) begin errors++; $display("FAIL write_p1: got %h/%h want 0f0f", busB, z_busB); end
  endtask

  task automatic test_collide();
    regWr = 1'b1; rw = 4'd3; busW = 16'h1234;
    regWr2 = 1'b1; rw2 = 4'd3; busW2 = 16'hABCD; rs = 4'd3; rt = 4'd4;
    #1;
    checks++; if (busA !== 16'h1234) begin errors++; $display("FAIL collide_bypass: got %h want 1234", busA); end
    tick();
    rw = 4'd3; busW = 16'h1111; rw2 = 4'd4; busW2 = 16'h2222; regWr = 1'b0; regWr2 = 1'b0;
    #1;
    checks++; if (busA !== 16'h1234 || z_busA !== 16'h1234) begin errors++; $display("FAIL collide_data: got %h/%h want 1234", busA, z_busA); end
    checks++; if (collide !== 1'b1 || z_collide !== 1'b1) begin errors++; $display("FAIL collide_set: got %b/%b want 1", collide, z_collide); end
    regWr = 1'b1; regWr2 = 1'b1;
    tick(); idle(); #1;
    checks++; if (collide !== 1'b0 || z_collide !== 1'b0) begin errors++; $display("FAIL collide_clear: got %b/%b want 0", collide, z_collide); end
    checks++; if (busA !== 16'h1111 || z_busA !== 16'h1111) begin errors++; $display("FAIL split_p0: got %h/%h want 1111", busA, z_busA); end
    checks++; if (busB !== 16'h2222 || z_busB !== 16'h2222) begin errors++; $display("FAIL split_p1: got %h/%h want 2222", busB, z_busB); end
  endtask

  task automatic test_scoreboard();
    lock = 1'b1; lock_addr = 4'd5; rs = 4'd5; rt = 4'd7;
    #1;
    checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0", busyA); end
    tick(); idle(); #1;
    checks++; if (busyA !== 1'b1 || z_busyA !== 1'b1) begin errors++; $display("FAIL lock_set: got %b/%b want 1", busyA, z_busyA); end
    regWr2 = 1'b1; rw2 = 4'd5; busW2 = 16'h00AA;
    #1;
    checks++; if (busyA !== 1'b0 || busA !== 16'h00AA) begin errors++; $display("FAIL load_bypass: got %b/%h want 0/00aa", busyA, busA); end
    checks++; if (z_busyA !== 1'b1 || z_busA !== 16'h0000) begin errors++; $display("FAIL load_nobypass: got %b/%h want 1/0000", z_busyA, z_busA); end
    tick(); idle(); #1;
    checks++; if (busyA !== 1'b0 || z_busyA !== 1'b0) begin errors++; $display("FAIL load_clear: got %b/%b want 0", busyA, z_busyA); end
    checks++; if (busA !== 16'h00AA || z_busA !== 16'h00AA) begin errors++; $display("FAIL load_data: got %h/%h want 00aa", busA, z_busA); end
    // Port-0 write to a busy register keeps it busy; port-1 write to an idle one leaves it idle.
    lock = 1'b1; lock_addr = 4'd7;
    tick(); idle();
    regWr = 1'b1; rw = 4'd7; busW = 16'h7777; regWr2 = 1'b1; rw2 = 4'd8; busW2 = 16'h8888;
    tick(); idle(); rs = 4'd8; #1;
    checks++; if (busyB !== 1'b1 || busB !== 16'h7777) begin errors++; $display("FAIL busy_p0_write: got %b/%h want 1/7777", busyB, busB); end
    checks++; if (z_busyA !== 1'b0 || z_busA !== 16'h8888) begin errors++; $display("FAIL idle_p1_write: got %b/%h want 0/8888", z_busyA, z_busA); end
  endtask

  task automatic test_lock_clear_reset();
    lock = 1'b1; lock_addr = 4'd6; regWr2 = 1'b1; rw2 = 4'd6; busW2 = 16'h0066; rs = 4'd6; rt = 4'd7;
    #1;
    checks++; if (busyA !== 1'b0) begin errors++; $display("FAIL lock_clear_same_cycle: got %b want 0", busyA); end
    tick(); idle(); #1;
    checks++; if (busyA !== 1'b1 || z_busyA !== 1'b1) begin errors++; $display("FAIL lock_wins: got %b/%b want 1", busyA, z_busyA); end
    checks++; if (busA !== 16'h0066) begin errors++; $display("FAIL lock_wins_data: got %h want 0066", busA); end
    reset = 1'b1; lock = 1'b1; lock_addr = 4'd9; regWr = 1'b1; rw = 4'd9; busW = 16'h9999;
    tick(); idle(); rt = 4'd9; #1;
    checks++; if (busA !== 16'h0000 || busyA !== 1'b0) begin errors++; $display("FAIL reset_reg6: got %h/%b want 0000/0", busA, busyA); end
    checks++; if (busB !== 16'h0000 || busyB !== 1'b0 || z_busyB !== 1'b0) begin errors++; $display("FAIL reset_ignores_ops: got %h/%b/%b want 0000/0/0", busB, busyB, z_busyB); end
  endtask

  task automatic test_zero_reg();
    regWr = 1'b1; rw = 4'd0; busW = 16'h5555; lock = 1'b1; lock_addr = 4'd0; rs = 4'd0; rt = 4'd0;
    #1;
    checks++; if (busA !== 16'h5555 || z_busA !== 16'h0000) begin errors++; $display("FAIL zero_bypass: got %h/%h want 5555/0000", busA, z_busA); end
    tick(); idle(); #1;
    checks++; if (busA !== 16'h5555 || busyA !== 1'b1) begin errors++; $display("FAIL reg0_normal: got %h/%b want 5555/1", busA, busyA); end
    checks++; if (z_busA !== 16'h0000 || z_busyA !== 1'b0) begin errors++; $display("FAIL reg0_zero: got %h/%b want 0000/0", z_busA, z_busyA); end
    regWr = 1'b1; rw = 4'd0; busW = 16'h1357; regWr2 = 1'b1; rw2 = 4'd0; busW2 = 16'h2468;
    tick(); idle(); #1;
    checks++; if (collide !== 1'b1 || z_collide !== 1'b0) begin errors++; $display("FAIL reg0_collide: got %b/%b want 1/0", collide, z_collide); end
    checks++; if (busB !== 16'h1357 || z_busB !== 16'h0000) begin errors++; $display("FAIL reg0_collide_data: got %h/%h want 1357/0000", busB, z_busB); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_v;
    for (int i = 10; i < 14; i++) begin
      regWr = 1'b1; rw = 4'(i); busW = 16'hA000 + 16'(i);
      tick();
    end
    idle();
    for (int i = 10; i < 14; i++) begin
      rs = 4'(i); rt = 4'(i); exp_v = 16'hA000 + 16'(i);
      #1;
      checks++; if (busA !== exp_v || z_busB !== exp_v) begin errors++; $display("FAIL b2b_reg%0d: got %h/%h want %h", i, busA, z_busB, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_write_bypass();
    test_collide();
    test_scoreboard();
    test_lock_clear_reset();
    test_zero_reg();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised successor to the CPU's 16x16 two-read/one-write register file.
- Adds a second write port (ALU writeback on port 0, memory-load writeback on port 1).
- Adds a per-register pending-load scoreboard, an optional read-during-write bypass, an optional hardwired-zero register 0, and synchronous clear.
- Sits between decode (rs/rt reads) and the two writeback paths.

Parameters:
- DATA_W, 16, register width in bits.
- ADDR_W, 4, address width; depth = 2**ADDR_W.
- BYPASS, 1, 1 = a read of a register being written this cycle returns the incoming write data.
- ZERO_REG, 0, 1 = register 0 always reads 0; writes and locks to it are ignored.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears the whole array and the scoreboard.
- rs  input  ADDR_W  read address A.
- rt  input  ADDR_W  read address B.
- busA  output  DATA_W  data at rs (combinational).
- busB  output  DATA_W  data at rt (combinational).
- busyA  output  1  register rs has a pending load.
- busyB  output  1  register rt has a pending load.
- regWr  input  1  write enable, port 0 (ALU).
- rw  input  ADDR_W  write address, port 0.
- busW  input  DATA_W  write data, port 0.
- regWr2  input  1  write enable, port 1 (load); also clears busy.
- rw2  input  ADDR_W  write address, port 1.
- busW2  input  DATA_W  write data, port 1.
- lock  input  1  mark register lock_addr as pending-load.
- lock_addr  input  ADDR_W  register to lock.
- collide  output  1  registered flag: port 0 and port 1 wrote the same register last cycle.

Behaviour:
- Reset (synchronous, active-high):
  - At a rising edge with reset=1: all registers := 0, all busy bits := 0, collide := 0.
  - All writes, locks and clears are ignored that cycle.
  - busA/busB read 0 and busyA/busyB read 0 from the next cycle.
  - Reset asserted mid-sequence discards any pending lock without a clear.
- Writes:
  - Take effect at the rising edge and are visible through the array on the following cycle.
  - Port 0 and port 1 may write different registers in the same cycle; both update.
  - If both write the same address, port 0 data is stored and collide := 1 for one cycle; otherwise collide := 0.
- Reads: combinational from the array, reflecting the last committed edge.
- Bypass:
  - Applies only when BYPASS=1.
  - If rs matches an enabled write address this cycle, busA = that port's data; port 0 wins on collision. Same rule for rt/busB.
  - When BYPASS=0, reads return the stored value until the edge.
- Scoreboard (busy[i], one bit per register):
  - Set: lock=1 sets busy[lock_addr] at the edge.
  - Clear: regWr2=1 clears busy[rw2] at the edge.
  - Lock and clear on the same address in one cycle: lock wins, busy stays 1 (a new load was issued).
  - Lock of an already-busy register: stays 1.
  - A port-0 write to a busy register writes the data; busy is unchanged.
  - A port-1 write to a non-busy register writes the data; busy stays 0.
- busy outputs:
  - busyA = busy[rs], except when BYPASS=1 and regWr2 & rw2==rs & no same-cycle lock of rs; then busyA = 0. busyB is symmetric.
- ZERO_REG=1, register 0:
  - Reads 0, including via bypass, with busy = 0.
  - Writes to it are dropped, and a port collision on it does not set collide.
  - lock_addr = 0 is ignored.
- No read/write latency other than the single edge described above; no stalls generated internally.

Test Plan:
- Reset, then rs=0, rt=15 -> busA=0x0000, busB=0x0000, busyA=busyB=0.
- regWr=1, rw=1, busW=0xFFFF; next cycle rs=1 -> busA=0xFFFF. With BYPASS=1, busA=0xFFFF in the same cycle; with BYPASS=0, busA=0x0000 in the same cycle.
- Same cycle: regWr, rw=3, busW=0x1234 and regWr2, rw2=3, busW2=0xABCD -> reg3=0x1234, collide=1 for exactly one cycle. Then rw=3, rw2=4 -> reg3 and reg4 both written, collide=0.
- lock=1, lock_addr=5 -> busyA=1 for rs=5. Then regWr2, rw2=5, busW2=0x00AA -> busyA=0 (same cycle with BYPASS=1, next cycle otherwise) and busA=0x00AA.
- Same cycle lock, lock_addr=6 and regWr2, rw2=6 -> busy[6] stays 1. Then reset=1 for one edge -> busy[6]=0 and reg6=0.
- ZERO_REG=1: regWr, rw=0, busW=0x5555 plus lock, lock_addr=0 -> busA (rs=0)=0x0000, busyA=0.
